// File: rtl/router_pkt_rx.sv
// Router output-port receiver: reads one packet at a time from the router FIFO,
// streams payload bytes to a sink and reports parity, address and stall errors.
module router_pkt_rx #(
  parameter logic [1:0] PORT_ADDR = 2'b00,
  parameter int         TIMEOUT   = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  output logic       read_enb,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic [5:0] rx_len,
  output logic [1:0] rx_addr,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       timeout_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, RD_HDR, CAP_HDR, STREAM, CHECK} state_t;

  localparam logic [6:0] TIMEOUT_C = 7'(TIMEOUT);

  state_t     state_q, state_d;
  logic [6:0] rem_q, rem_d;
  logic [6:0] cap_q, cap_d;
  logic [6:0] stall_q, stall_d;
  logic [7:0] acc_q, acc_d;
  logic [5:0] len_q, len_d;
  logic [1:0] addr_q, addr_d;
  logic       perr_q, perr_d;
  logic       tout_q, tout_d;
  logic       pend_q, pend_d;
  logic       rxv_q, rxv_d;
  logic [7:0] rxd_q, rxd_d;
  logic       sop_q, sop_d;
  logic       eop_q, eop_d;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    cap_d    = cap_q;
    stall_d  = stall_q;
    acc_d    = acc_q;
    len_d    = len_q;
    addr_d   = addr_q;
    perr_d   = perr_q;
    tout_d   = 1'b0;
    pend_d   = 1'b0;
    rxv_d    = 1'b0;
    rxd_d    = rxd_q;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    read_enb = 1'b0;

    case (state_q)
      IDLE: begin
        if (vld_out) state_d = RD_HDR;
      end
      RD_HDR: begin
        read_enb = vld_out;
        if (vld_out) state_d = CAP_HDR;
      end
      CAP_HDR: begin
        len_d   = data_out[7:2];
        addr_d  = data_out[1:0];
        acc_d   = data_out;
        rem_d   = {1'b0, data_out[7:2]} + 7'd1;
        cap_d   = 7'd0;
        stall_d = 7'd0;
        state_d = STREAM;
      end
      STREAM: begin
        read_enb = vld_out & rx_ready & (rem_q != 7'd0);
        pend_d   = read_enb;
        if (read_enb) begin
          rem_d   = rem_q - 7'd1;
          stall_d = 7'd0;
        end else if (!vld_out && rem_q != 7'd0) begin
          stall_d = stall_q + 7'd1;
          if (stall_q + 7'd1 == TIMEOUT_C) begin
            tout_d  = 1'b1;
            state_d = IDLE;
          end
        end
        // Data arrives one cycle after the read; the byte after the last payload is parity.
        if (pend_q) begin
          if (cap_q == {1'b0, len_q}) begin
            perr_d  = (data_out != acc_q);
            state_d = CHECK;
          end else begin
            rxv_d = 1'b1;
            rxd_d = data_out;
            acc_d = acc_q ^ data_out;
            sop_d = (cap_q == 7'd0);
            eop_d = (cap_q + 7'd1 == {1'b0, len_q});
            cap_d = cap_q + 7'd1;
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= 7'd0;
      cap_q   <= 7'd0;
      stall_q <= 7'd0;
      acc_q   <= 8'd0;
      len_q   <= 6'd0;
      addr_q  <= 2'd0;
      perr_q  <= 1'b0;
      tout_q  <= 1'b0;
      pend_q  <= 1'b0;
      rxv_q   <= 1'b0;
      rxd_q   <= 8'd0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cap_q   <= cap_d;
      stall_q <= stall_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      perr_q  <= perr_d;
      tout_q  <= tout_d;
      pend_q  <= pend_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign rx_valid    = rxv_q;
  assign rx_data     = rxd_q;
  assign rx_sop      = sop_q;
  assign rx_eop      = eop_q;
  assign rx_len      = len_q;
  assign rx_addr     = addr_q;
  assign pkt_done    = (state_q == CHECK);
  assign parity_err  = (state_q == CHECK) & perr_q;
  assign addr_err    = (state_q == CHECK) & (addr_q != PORT_ADDR);
  assign timeout_err = tout_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/router_pkt_rx.md
ROUTER_PKT_RX -- requirements
Module: router_pkt_rx

Interface
REQ-001 SHALL have parameter PORT_ADDR, 2'b00, router output port address this receiver is attached to.
REQ-002 SHALL have parameter TIMEOUT, 63, maximum consecutive stall cycles (vld_out low) tolerated mid-packet.
REQ-003 SHALL have port clock, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port vld_out, input, 1, router output FIFO not empty.
REQ-006 SHALL have port data_out, input, 8, router FIFO read data; valid the cycle after read_enb sampled high.
REQ-007 SHALL have port read_enb, output, 1, FIFO read strobe.
REQ-008 SHALL have port rx_ready, input, 1, downstream sink may accept a byte next cycle.
REQ-009 SHALL have port rx_data, output, 8, payload byte to sink.
REQ-010 SHALL have port rx_valid, output, 1, rx_data valid; sink always accepts, no backpressure on this cycle.
REQ-011 SHALL have ports rx_sop and rx_eop, output, 1 each, first and last payload byte markers, qualified by rx_valid.
REQ-012 SHALL have ports rx_len, output, 6, and rx_addr, output, 2, fields of the last captured header.
REQ-013 SHALL have ports pkt_done, parity_err, addr_err, timeout_err, output, 1 each, single-cycle status pulses.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 Packet format: header {len[5:0], addr[1:0]}, then len payload bytes (0..63), then one parity byte = XOR of header and all payload bytes.
REQ-016 FSM states: IDLE, RD_HDR, CAP_HDR, STREAM, CHECK.
REQ-017 IDLE: read_enb=0; vld_out=1 -> RD_HDR.
REQ-018 RD_HDR: read_enb=1 for exactly one cycle -> CAP_HDR.
REQ-019 CAP_HDR: read_enb=0; capture data_out into rx_len/rx_addr; parity accumulator = header; remaining-read counter = len+1; captured counter = 0 -> STREAM.
REQ-020 STREAM: read_enb = vld_out & rx_ready & (remaining != 0); remaining decrements on each read.
REQ-021 One cycle after each STREAM read, the byte on data_out is captured: captured < len -> rx_valid=1, rx_data=data_out, accumulator ^= byte; captured == len -> parity byte, compared to accumulator, rx_valid=0.
REQ-022 rx_sop high with the first payload byte; rx_eop high with payload byte len-1; both high on the same byte when len=1.
REQ-023 len=0: STREAM issues exactly one read (parity); no rx_valid; rx_sop/rx_eop never asserted.
REQ-024 After parity capture -> CHECK; CHECK pulses pkt_done, parity_err if parity mismatch, addr_err if rx_addr != PORT_ADDR; then -> IDLE.
REQ-025 Back-to-back packets: CHECK -> IDLE -> RD_HDR; minimum 2 idle cycles of read_enb between packets.
REQ-026 Stall counter counts STREAM cycles with vld_out=0 and remaining != 0; it clears on any read; rx_ready low alone does not count.
REQ-027 Stall counter reaching TIMEOUT -> timeout_err pulse, no pkt_done, -> IDLE, remaining bytes left unread.
REQ-028 read_enb SHALL never be asserted while vld_out=0.
REQ-029 Counters 7-bit; remaining never wraps below 0.
REQ-030 addr_err does not suppress payload delivery or pkt_done.

Reset
REQ-031 reset asserted, including mid-packet: state IDLE, read_enb=0, rx_valid=0, rx_sop=0, rx_eop=0, rx_data=0, rx_len=0, rx_addr=0, all pulses 0, busy=0, all counters and accumulator 0, immediately and asynchronously.
REQ-032 After reset release, the next byte read is treated as a header.

Verification
REQ-033 PORT_ADDR=2; header 0x16, payload 01 02 03 04 05, parity 0x17, rx_ready=1 -> 5 rx_valid beats 01..05 on consecutive cycles, sop on 01, eop on 05, pkt_done=1, parity_err=0, addr_err=0, rx_len=5, rx_addr=2.
REQ-034 Same packet, parity byte 0x18 -> identical payload delivery, pkt_done=1, parity_err=1.
REQ-035 Header 0x02 (len 0), parity 0x02 -> exactly 2 read_enb pulses total, no rx_valid, pkt_done=1, no errors.
REQ-036 0x16 packet, rx_ready low 3 cycles after second payload read, vld_out low 10 cycles later in the packet -> read_enb held low during both stalls, byte order preserved, pkt_done=1, no timeout.
REQ-037 TIMEOUT=63, vld_out held low 63 cycles after second payload byte -> timeout_err pulse, busy=0, no pkt_done; reset asserted during a later payload -> all outputs 0 in the same cycle, next read treated as header.
